fetch_unit: RTL and testbench

- Parametrised, decoupled instruction-fetch front end for the next-generation RISC-V core. It replaces the combinational PC/+4/branch-mux path.
- Holds the fetch PC and issues requests to a variable-latency instruction memory over a valid/ready handshake, one outstanding request at a time.
- Buffers returned instructions with their PCs in a FIFO feeding decode.
- Accepts branch/jump redirects, which flush the FIFO and discard any stale in-flight response.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC register, one-outstanding imem request,
// instruction/PC FIFO toward decode, redirect flush with stale-response drop.
//
// Ports:
//   clk, PCreset           clock (rising edge), async active-low reset
//   imem_req_valid/ready   request handshake toward instruction memory
//   imem_req_addr          word-aligned fetch address
//   imem_rsp_valid/data    single-cycle response pulse and instruction
//   redirect_valid/target  taken branch/jump; flushes and refetches target
//   inst_valid/ready       FIFO head handshake toward decode
//   inst_data/pc/pc4       head instruction, its PC and PC+4
//   fifo_count             occupied FIFO entries
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ILEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       PCreset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [ILEN-1:0]            inst_data,
    output logic [XLEN-1:0]            inst_pc,
    output logic [XLEN-1:0]            inst_pc4,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            drop_q;

    logic [ILEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic has_space;
    logic req_fire;
    logic rsp_take;
    logic push;
    logic pop;

    // The single in-flight slot is already reserved by the S_WAIT state,
    // so a free slot now is enough to guarantee room for the response.
    assign has_space = (count_q < DEPTH_C);
    assign req_fire  = imem_req_valid && imem_req_ready;

    // Any response seen in S_WAIT ends the transaction, whether it is
    // kept, dropped as stale, or killed by a same-cycle redirect.
    assign rsp_take  = (state_q == S_WAIT) && imem_rsp_valid;
    assign push      = rsp_take && !drop_q && !redirect_valid;
    assign pop       = inst_valid && inst_ready;

    always_ff @(posedge clk or negedge PCreset) begin
        if (!PCreset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Gating with reset keeps the request low while held in reset.
                imem_req_valid = PCreset && has_space && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge PCreset) begin
        if (!PCreset) begin
            fetch_pc_q <= RESET_VECTOR & ALIGN_MASK;
            req_pc_q   <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_target & ALIGN_MASK;
        end else if (req_fire) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            req_pc_q   <= fetch_pc_q;
        end
    end

    // Only one request is ever outstanding, so one flag is enough to
    // remember that the pending response belongs to a squashed path.
    always_ff @(posedge clk or negedge PCreset) begin
        if (!PCreset) begin
            drop_q <= 1'b0;
        end else if (rsp_take) begin
            drop_q <= 1'b0;
        end else if (redirect_valid && (state_q == S_WAIT)) begin
            drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge PCreset) begin
        if (!PCreset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem_req_addr = fetch_pc_q;

    assign inst_valid = (count_q != '0) && !redirect_valid;
    assign inst_data  = data_mem[rd_ptr_q];
    assign inst_pc    = pc_mem[rd_ptr_q];
    assign inst_pc4   = inst_pc + PC_STEP;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus
// hand sequences for reset mid-transaction and 16-bit PC wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        PCreset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [2:0]  fifo_count;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_VECTOR(32'h100)
    ) dut (
        .clk(clk), .PCreset(PCreset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .fifo_count(fifo_count)
    );

    logic        w_rst;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [15:0] w_req_addr;
    logic        w_rsp_valid;
    logic [15:0] w_rsp_data;
    logic        w_rd_valid;
    logic [15:0] w_rd_target;
    logic        w_inst_valid;
    logic        w_inst_ready;
    logic [15:0] w_inst_data;
    logic [15:0] w_inst_pc;
    logic [15:0] w_inst_pc4;
    logic [1:0]  w_count;

    fetch_unit #(
        .XLEN(16), .ILEN(16), .DEPTH(2), .RESET_VECTOR(16'hFFF8)
    ) dut16 (
        .clk(clk), .PCreset(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_rd_valid), .redirect_target(w_rd_target),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_pc4(w_inst_pc4),
        .fifo_count(w_count)
    );

    typedef struct {
        bit          rst;
        bit          rq;
        bit          rsp;
        logic [31:0] rspd;
        bit          rd;
        logic [31:0] rdt;
        bit          inr;
        bit          erv;
        logic [31:0] ea;
        bit          eiv;
        logic [31:0] ep;
        int          ec;
    } vec_t;

    vec_t vq[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] dval(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int rst, input int rq, input int rsp,
                       input logic [31:0] ra, input int rd,
                       input logic [31:0] rdt, input int inr,
                       input int erv, input logic [31:0] ea,
                       input int eiv, input logic [31:0] ep, input int ec);
        vec_t v;
        v.rst  = (rst != 0);
        v.rq   = (rq != 0);
        v.rsp  = (rsp != 0);
        v.rspd = dval(ra);
        v.rd   = (rd != 0);
        v.rdt  = rdt;
        v.inr  = (inr != 0);
        v.erv  = (erv != 0);
        v.ea   = ea;
        v.eiv  = (eiv != 0);
        v.ep   = ep;
        v.ec   = ec;
        vq.push_back(v);
    endtask

    // Holds reset with busy-looking inputs, checks quiet outputs, then
    // releases on a falling edge so the caller drives the first vector.
    task automatic do_reset();
        @(negedge clk);
        PCreset         = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'hBAD0_BAD0;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b1;
        #1;
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        PCreset = 1'b1;
    endtask

    initial begin
        vec_t v;

        PCreset         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        inst_ready      = 1'b0;
        w_rst           = 1'b0;
        w_req_ready     = 1'b0;
        w_rsp_valid     = 1'b0;
        w_rsp_data      = '0;
        w_rd_valid      = 1'b0;
        w_rd_target     = '0;
        w_inst_ready    = 1'b0;

        // A: zero-wait memory, decode always ready, then req_ready stall
        add(1,1,0,0,0,0,1, 1,'h100,0,0,0);
        add(0,1,1,'h100,0,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h104,1,'h100,1);
        add(0,1,1,'h104,0,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h108,1,'h104,1);
        add(0,1,1,'h108,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,'h10C,1,'h108,1);
        add(0,0,0,0,0,0,1, 1,'h10C,0,0,0);
        add(0,0,0,0,0,0,1, 1,'h10C,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h10C,0,0,0);
        add(0,0,1,'h10C,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,'h110,1,'h10C,1);

        // B: decode stalled until FIFO full, then drain and resume
        add(1,1,0,0,0,0,0, 1,'h100,0,0,0);
        add(0,1,1,'h100,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0,0,0, 1,'h104,1,'h100,1);
        add(0,1,1,'h104,0,0,0, 0,0,1,'h100,1);
        add(0,1,0,0,0,0,0, 1,'h108,1,'h100,2);
        add(0,1,1,'h108,0,0,0, 0,0,1,'h100,2);
        add(0,1,0,0,0,0,0, 1,'h10C,1,'h100,3);
        add(0,1,1,'h10C,0,0,0, 0,0,1,'h100,3);
        add(0,1,0,0,0,0,0, 0,0,1,'h100,4);
        add(0,1,0,0,0,0,0, 0,0,1,'h100,4);
        add(0,1,0,0,0,0,1, 0,0,1,'h100,4);
        add(0,1,0,0,0,0,1, 1,'h110,1,'h104,3);
        add(0,1,1,'h110,0,0,1, 0,0,1,'h108,2);
        add(0,0,0,0,0,0,1, 1,'h114,1,'h10C,2);
        add(0,0,0,0,0,0,1, 1,'h114,1,'h110,1);
        add(0,0,0,0,0,0,0, 1,'h114,0,0,0);

        // C: redirect in S_WAIT with late stale response; redirect in S_REQ
        add(1,1,0,0,0,0,1, 1,'h100,0,0,0);
        add(0,0,0,0,1,'h2002,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,0,0);
        add(0,1,1,'h100,0,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h2000,0,0,0);
        add(0,1,1,'h2000,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,'h2004,1,'h2000,1);
        add(0,1,0,0,1,'h3007,1, 0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h3004,0,0,0);
        add(0,1,1,'h3004,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,'h3008,1,'h3004,1);

        // D: redirect with response and pop pending; back-to-back redirects
        add(1,1,0,0,0,0,0, 1,'h100,0,0,0);
        add(0,1,1,'h100,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0,0,0, 1,'h104,1,'h100,1);
        add(0,1,1,'h104,0,0,0, 0,0,1,'h100,1);
        add(0,1,0,0,0,0,0, 1,'h108,1,'h100,2);
        add(0,1,1,'h108,1,'h4000,1, 0,0,0,0,2);
        add(0,1,0,0,0,0,1, 1,'h4000,0,0,0);
        add(0,1,1,'h4000,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,'h4004,1,'h4000,1);
        add(0,1,0,0,0,0,1, 1,'h4004,0,0,0);
        add(0,0,0,0,1,'h5000,1, 0,0,0,0,0);
        add(0,0,0,0,1,'h6000,1, 0,0,0,0,0);
        add(0,1,1,'h4004,0,0,1, 0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,'h6000,0,0,0);
        add(0,1,1,'h6000,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,'h6004,1,'h6000,1);

        foreach (vq[i]) begin
            v = vq[i];
            if (v.rst) do_reset();
            else @(negedge clk);
            imem_req_ready  = v.rq;
            imem_rsp_valid  = v.rsp;
            imem_rsp_data   = v.rspd;
            redirect_valid  = v.rd;
            redirect_target = v.rdt;
            inst_ready      = v.inr;
            #1;
            chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid),
                32'(v.erv));
            if (v.erv)
                chk($sformatf("v%0d req_addr", i), imem_req_addr, v.ea);
            chk($sformatf("v%0d inst_valid", i), 32'(inst_valid),
                32'(v.eiv));
            if (v.eiv) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, v.ep);
                chk($sformatf("v%0d inst_data", i), inst_data, dval(v.ep));
                chk($sformatf("v%0d inst_pc4", i), inst_pc4,
                    v.ep + 32'd4);
            end
            chk($sformatf("v%0d fifo_count", i), 32'(fifo_count),
                32'(v.ec));
        end

        // Reset while a request is in flight; stale pulse after release
        @(negedge clk);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        @(negedge clk);
        PCreset        = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("midrst req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        PCreset        = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk("postrst req_valid", 32'(imem_req_valid), 32'd1);
        chk("postrst req_addr", imem_req_addr, 32'h100);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("stale fifo_count", 32'(fifo_count), 32'd0);
        chk("stale inst_valid", 32'(inst_valid), 32'd0);
        chk("stale req_addr", imem_req_addr, 32'h100);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = dval(32'h100);
        #1;
        chk("postrst wait req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk("postrst inst_valid", 32'(inst_valid), 32'd1);
        chk("postrst inst_pc", inst_pc, 32'h100);
        chk("postrst inst_data", inst_data, dval(32'h100));
        chk("postrst fifo_count", 32'(fifo_count), 32'd1);

        // 16-bit PC wraps from 0xFFFC to 0x0000
        @(negedge clk);
        w_rst        = 1'b1;
        w_req_ready  = 1'b1;
        w_inst_ready = 1'b1;
        #1;
        chk("w16 req_valid0", 32'(w_req_valid), 32'd1);
        chk("w16 req_addr0", 32'(w_req_addr), 32'h0000_FFF8);
        @(negedge clk);
        w_rsp_valid = 1'b1;
        w_rsp_data  = 16'h1111;
        #1;
        chk("w16 wait req_valid", 32'(w_req_valid), 32'd0);
        @(negedge clk);
        w_rsp_valid = 1'b0;
        #1;
        chk("w16 req_addr1", 32'(w_req_addr), 32'h0000_FFFC);
        chk("w16 inst_pc1", 32'(w_inst_pc), 32'h0000_FFF8);
        chk("w16 inst_data1", 32'(w_inst_data), 32'h0000_1111);
        chk("w16 inst_pc4_1", 32'(w_inst_pc4), 32'h0000_FFFC);
        @(negedge clk);
        w_rsp_valid = 1'b1;
        w_rsp_data  = 16'h2222;
        @(negedge clk);
        w_rsp_valid = 1'b0;
        w_req_ready = 1'b0;
        #1;
        chk("w16 req_valid2", 32'(w_req_valid), 32'd1);
        chk("w16 req_addr wrap", 32'(w_req_addr), 32'h0000_0000);
        chk("w16 inst_pc2", 32'(w_inst_pc), 32'h0000_FFFC);
        chk("w16 inst_data2", 32'(w_inst_data), 32'h0000_2222);
        chk("w16 inst_pc4 wrap", 32'(w_inst_pc4), 32'h0000_0000);
        chk("w16 fifo_count", 32'(w_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
